iterative_multiplier: RTL and testbench
=======================================

ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, width of the write-back address.
REQ-003 SHALL have port Clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iStart  input  1  request a multiply; sampled only in IDLE.
REQ-006 SHALL have port iOperandA  input  DATA_WIDTH  signed multiplicand, driven from the RAM read-port-0 output.
REQ-007 SHALL have port iOperandB  input  DATA_WIDTH  signed multiplier, driven from the RAM read-port-1 output.
REQ-008 SHALL have port iDestAddress  input  ADDR_WIDTH  RAM write-back address, captured with the operands.
REQ-009 SHALL have port oBusy  output  1  high while an operation is in progress (state not IDLE).
REQ-010 SHALL have port oDone  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port oWriteEnable  output  1  RAM write strobe; identical timing to oDone.
REQ-012 SHALL have port oWriteAddress  output  ADDR_WIDTH  captured iDestAddress.
REQ-013 SHALL have port oDataOut  output  DATA_WIDTH  signed low DATA_WIDTH bits of the product.
REQ-014 SHALL have port oOverflow  output  1  product does not fit in signed DATA_WIDTH; valid with oDone.

Function
REQ-015 SHALL implement states IDLE, RUN, SIGN; all outputs registered except oBusy, which is decoded from state.
REQ-016 IDLE: on edge E0 with iStart=1, SHALL capture |iOperandA|, |iOperandB| as DATA_WIDTH-bit unsigned magnitudes, sign = A[MSB] XOR B[MSB], iDestAddress; clear 2*DATA_WIDTH accumulator and bit counter; go to RUN.
REQ-017 RUN: each edge SHALL add the shifted multiplicand to the accumulator if the current multiplier bit is 1, advance one bit, increment counter; after exactly DATA_WIDTH RUN edges (E1..E_W) SHALL go to SIGN.
REQ-018 SIGN: on edge E_(W+1) SHALL negate the accumulator if sign=1, load oDataOut with the low DATA_WIDTH bits, set oOverflow, set oDone=oWriteEnable=1, go to IDLE.
REQ-019 oDone/oWriteEnable SHALL be high for exactly one cycle (E_(W+1) to E_(W+2)); oDataOut, oWriteAddress, oOverflow SHALL hold until the next SIGN edge or reset.
REQ-020 oOverflow SHALL be 1 iff the signed 2*DATA_WIDTH product is outside [-2^(W-1), 2^(W-1)-1].
REQ-021 Magnitude of -2^(W-1) SHALL be represented exactly (unsigned 2^(W-1)); no saturation anywhere, result is wrap-truncated.
REQ-022 iStart SHALL be ignored in RUN and SIGN; operand/address changes after E0 SHALL not affect the result.
REQ-023 A new iStart SHALL be accepted on edge E_(W+2) (first IDLE edge), giving one result per W+2 cycles back-to-back.
REQ-024 A zero operand SHALL still take the full W+1 cycle latency.

Reset
REQ-025 Reset=1 SHALL immediately, without clock, force state IDLE and oDone, oWriteEnable, oWriteAddress, oDataOut, oOverflow, accumulator and counter to 0; oBusy=0.
REQ-026 Reset asserted mid-RUN/SIGN SHALL abort the operation with no write pulse; first iStart after release SHALL be processed normally.

Verification (DATA_WIDTH=32, ADDR_WIDTH=8)
REQ-027 A=3, B=-4, dest=0x05, iStart at E0 -> oDone/oWriteEnable high only after E33, oDataOut=0xFFFFFFF4, oWriteAddress=0x05, oOverflow=0; oBusy high E0..E33.
REQ-028 A=0x7FFFFFFF, B=2 -> oDataOut=0xFFFFFFFE, oOverflow=1; A=0x80000000, B=1 -> 0x80000000, oOverflow=0; A=0x80000000, B=-1 -> 0x80000000, oOverflow=1.
REQ-029 iStart held high continuously with changing operands -> results issued every 34 cycles, each using operands present at its accept edge; mid-operation pulses ignored.
REQ-030 Reset pulsed asynchronously between E10 and E11 of an operation -> all outputs 0 at once, no oWriteEnable pulse; next operation 5*6 -> 30.
REQ-031 A=0, B=0x80000000 -> oDataOut=0, oOverflow=0, latency still 33 edges.

Source files
------------

// File: rtl/iterative_multiplier.sv
// Sequential shift-and-add signed multiplier with RAM write-back handshake.
// One product every DATA_WIDTH+2 cycles; magnitudes are multiplied, sign applied at the end.
module iterative_multiplier #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DATA_WIDTH-1:0] iOperandA,
  input  logic [DATA_WIDTH-1:0] iOperandB,
  input  logic [ADDR_WIDTH-1:0] iDestAddress,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oOverflow
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Unsigned magnitude; the most negative value maps to 2^(W-1) without saturation.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
    if (v[DATA_WIDTH-1]) begin
      magnitude = ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] v, input logic neg);
    if (neg) begin
      apply_sign = ~v + {{(PROD_W-1){1'b0}}, 1'b1};
    end else begin
      apply_sign = v;
    end
  endfunction

  // The product fits iff all bits from the result MSB upward are copies of the sign.
  function automatic logic fits_signed(input logic [PROD_W-1:0] p);
    logic [PROD_W-DATA_WIDTH:0] upper;
    upper       = p[PROD_W-1:DATA_WIDTH-1];
    fits_signed = (&upper) | ~(|upper);
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    busy_s;
  logic                    accept_s;
  logic                    step_s;
  logic                    finish_s;

  logic [PROD_W-1:0]       mcand_r;
  logic [DATA_WIDTH-1:0]   mplier_r;
  logic [PROD_W-1:0]       acc_r;
  logic [CNT_W-1:0]        count_r;
  logic                    sign_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [PROD_W-1:0]       product_s;

  logic                    done_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    ovf_r;
  logic [ADDR_WIDTH-1:0]   waddr_r;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (iStart) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_CNT) begin
          next_state_s = SIGN;
        end else begin
          next_state_s = RUN;
        end
      end
      SIGN:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    busy_s   = 1'b0;
    accept_s = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE:    accept_s = iStart;
      RUN: begin
        busy_s = 1'b1;
        step_s = 1'b1;
      end
      SIGN: begin
        busy_s   = 1'b1;
        finish_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // Operand capture and shift-and-add iteration.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      count_r  <= '0;
      sign_r   <= 1'b0;
      addr_r   <= '0;
    end else if (accept_s) begin
      mcand_r  <= {{DATA_WIDTH{1'b0}}, magnitude(iOperandA)};
      mplier_r <= magnitude(iOperandB);
      acc_r    <= '0;
      count_r  <= '0;
      sign_r   <= iOperandA[DATA_WIDTH-1] ^ iOperandB[DATA_WIDTH-1];
      addr_r   <= iDestAddress;
    end else if (step_s) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + CNT_W'(1);
    end
  end

  assign product_s = apply_sign(acc_r, sign_r);

  // Result registers; loaded only on the SIGN edge and held otherwise.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      done_r  <= 1'b0;
      data_r  <= '0;
      ovf_r   <= 1'b0;
      waddr_r <= '0;
    end else begin
      done_r <= finish_s;
      if (finish_s) begin
        data_r  <= product_s[DATA_WIDTH-1:0];
        ovf_r   <= ~fits_signed(product_s);
        waddr_r <= addr_r;
      end
    end
  end

  assign oBusy         = busy_s;
  assign oDone         = done_r;
  assign oWriteEnable  = done_r;
  assign oWriteAddress = waddr_r;
  assign oDataOut      = data_r;
  assign oOverflow     = ovf_r;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed-vector bench for iterative_multiplier (DATA_WIDTH=32, ADDR_WIDTH=8).
module tb_iterative_multiplier;
  localparam int W  = 32;
  localparam int AW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iStart = 1'b0;
  logic [W-1:0]  iOperandA = 32'd0;
  logic [W-1:0]  iOperandB = 32'd0;
  logic [AW-1:0] iDestAddress = 8'd0;
  logic          oBusy;
  logic          oDone;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [W-1:0]  oDataOut;
  logic          oOverflow;

  int checks = 0;
  int errors = 0;

  iterative_multiplier #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iOperandA(iOperandA), .iOperandB(iOperandB), .iDestAddress(iDestAddress),
    .oBusy(oBusy), .oDone(oDone), .oWriteEnable(oWriteEnable),
    .oWriteAddress(oWriteAddress), .oDataOut(oDataOut), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; accept happens on the next posedge, then inputs are scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d, input logic hold);
    iStart = 1'b1; iOperandA = a; iOperandB = b; iDestAddress = d;
    @(posedge Clock); @(negedge Clock);
    check_value("busy_after_accept", oBusy, 1);
    iStart = hold; iOperandA = ~a; iOperandB = b + 32'd12345; iDestAddress = ~d;
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] data,
                               input logic ovf, input logic [AW-1:0] d);
    int n;
    logic busy_gap;
    n = 0;
    busy_gap = 1'b0;
    while (n < 40) begin
      @(posedge Clock); @(negedge Clock);
      n++;
      if (oDone) break;
      if (!oBusy) busy_gap = 1'b1;
    end
    check_value({tag, "_latency"}, n, 33);
    check_value({tag, "_busy"}, busy_gap, 0);
    check_value({tag, "_we"}, oWriteEnable, 1);
    check_value({tag, "_data"}, oDataOut, data);
    check_value({tag, "_ovf"}, oOverflow, ovf);
    check_value({tag, "_addr"}, oWriteAddress, d);
    check_value({tag, "_idle"}, oBusy, 0);
  endtask

  task automatic expect_hold(input string tag, input logic [W-1:0] data);
    @(posedge Clock); @(negedge Clock);
    check_value({tag, "_done_low"}, {oDone, oWriteEnable}, 0);
    check_value({tag, "_held"}, oDataOut, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    @(negedge Clock); @(negedge Clock);
    check_value("reset_outputs",
                {oBusy, oDone, oWriteEnable, oOverflow, oWriteAddress, oDataOut}, 0);
    Reset = 1'b0;
    @(negedge Clock);

    issue(32'd3, 32'hFFFFFFFC, 8'h05, 1'b0);
    expect_result("m3xm4", 32'hFFFFFFF4, 1'b0, 8'h05);
    expect_hold("m3xm4", 32'hFFFFFFF4);

    issue(32'h7FFFFFFF, 32'd2, 8'h06, 1'b0);
    expect_result("maxx2", 32'hFFFFFFFE, 1'b1, 8'h06);
    expect_hold("maxx2", 32'hFFFFFFFE);

    issue(32'h80000000, 32'd1, 8'h07, 1'b0);
    expect_result("minx1", 32'h80000000, 1'b0, 8'h07);
    expect_hold("minx1", 32'h80000000);

    issue(32'h80000000, 32'hFFFFFFFF, 8'h08, 1'b0);
    expect_result("minxm1", 32'h80000000, 1'b1, 8'h08);
    expect_hold("minxm1", 32'h80000000);

    issue(32'd0, 32'h80000000, 8'h09, 1'b0);
    expect_result("zero", 32'd0, 1'b0, 8'h09);
    expect_hold("zero", 32'd0);

    issue(32'h00010000, 32'h00010000, 8'h0A, 1'b0);
    expect_result("2p32", 32'd0, 1'b1, 8'h0A);
    expect_hold("2p32", 32'd0);

    // iStart held high: each result 34 cycles apart, operands taken at accept edge.
    issue(32'd2, 32'd3, 8'h11, 1'b1);
    expect_result("b2b0", 32'd6, 1'b0, 8'h11);
    issue(32'd4, 32'd5, 8'h12, 1'b1);
    expect_result("b2b1", 32'd20, 1'b0, 8'h12);
    issue(32'hFFFFFFF9, 32'hFFFFFFFA, 8'h13, 1'b0);
    expect_result("b2b2", 32'd42, 1'b0, 8'h13);
    expect_hold("b2b2", 32'd42);

    // Asynchronous reset between E10 and E11.
    issue(32'd9, 32'd9, 8'h21, 1'b0);
    repeat (10) begin
      @(posedge Clock); @(negedge Clock);
    end
    #1 Reset = 1'b1;
    #1;
    check_value("async_reset",
                {oBusy, oDone, oWriteEnable, oOverflow, oWriteAddress, oDataOut}, 0);
    #1 Reset = 1'b0;
    we_seen = 0;
    repeat (40) begin
      @(posedge Clock); @(negedge Clock);
      if (oWriteEnable) we_seen = 1;
    end
    check_value("abort_no_write", we_seen, 0);
    issue(32'd5, 32'd6, 8'h22, 1'b0);
    expect_result("after_reset", 32'd30, 1'b0, 8'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
